seg7_scan_ctrl: RTL and testbench

- Time-multiplexing controller for the six-digit one-hot 7-segment decoder.
- Drives the decoder's value select (data1, 3 b) and its digit select (data2, 3 b: 1..6 = single digit, 0 = all digits).
- Holds a double-buffered 6-entry digit register file; new values are committed atomically at frame boundaries.
- Provides a lamp-test sequence that steps every segment pattern across all digits.

---
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a six-digit 7-segment decoder: double-buffered digit
// registers, frame-synchronous commits and an all-digit lamp-test sequence.
module seg7_scan_ctrl #(
  parameter  int DWELL = 50000,
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lamp_req,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic       commit,
  output logic [2:0] data1,
  output logic [2:0] data2,
  output logic       disp_en,
  output logic       frame_tick,
  output logic       commit_pend,
  output logic       lamp_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] LAMP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             lamp_pend;
  logic [2:0]       shadow [6];
  logic [2:0]       active [6];

  logic       bnd;
  logic       copy_slot;
  logic       do_copy;
  logic [2:0] idx_nxt;
  logic [2:0] first_val;

  // Copies happen in IDLE or on the edge that wraps the scan back to digit 1.
  always_comb begin
    bnd       = (cnt == CNT_W'(DWELL - 1));
    copy_slot = (state == IDLE) || ((state == SCAN) && bnd && (idx == 3'd5));
    do_copy   = copy_slot && (commit_pend || commit);
    idx_nxt   = idx + 3'd1;
    first_val = do_copy ? shadow[0] : active[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      lamp_pend   <= 1'b0;
      data1       <= 3'd0;
      data2       <= 3'd0;
      disp_en     <= 1'b0;
      frame_tick  <= 1'b0;
      commit_pend <= 1'b0;
      lamp_done   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= 3'd0;
        active[i] <= 3'd0;
      end
    end else begin
      frame_tick  <= 1'b0;
      lamp_done   <= 1'b0;
      commit_pend <= copy_slot ? 1'b0 : (commit_pend | commit);
      if (wr_en && (wr_addr < 3'd6))
        shadow[wr_addr] <= wr_data;
      if (do_copy)
        for (int i = 0; i < 6; i++) active[i] <= shadow[i];

      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= 3'd0;
          if (lamp_req || lamp_pend) begin
            state     <= LAMP;
            lamp_pend <= 1'b1;
            data1     <= 3'd0;
            data2     <= 3'd0;
            disp_en   <= 1'b1;
          end else if (en) begin
            state   <= SCAN;
            data1   <= first_val;
            data2   <= 3'd1;
            disp_en <= 1'b1;
          end else begin
            data1   <= 3'd0;
            data2   <= 3'd0;
            disp_en <= 1'b0;
          end
        end

        SCAN: begin
          if (lamp_req)
            lamp_pend <= 1'b1;
          if (!bnd) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (!en) begin
              state   <= IDLE;
              idx     <= 3'd0;
              data1   <= 3'd0;
              data2   <= 3'd0;
              disp_en <= 1'b0;
            end else if (idx == 3'd5) begin
              // Frame wrap: the tick fires even when handing over to lamp test.
              frame_tick <= 1'b1;
              idx        <= 3'd0;
              if (lamp_pend || lamp_req) begin
                state <= LAMP;
                data1 <= 3'd0;
                data2 <= 3'd0;
              end else begin
                data1 <= first_val;
                data2 <= 3'd1;
              end
            end else begin
              idx   <= idx_nxt;
              data1 <= active[idx_nxt];
              data2 <= idx_nxt + 3'd1;
            end
          end
        end

        LAMP: begin
          if (!bnd) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (idx == 3'd7) begin
              lamp_done <= 1'b1;
              lamp_pend <= 1'b0;
              idx       <= 3'd0;
              if (en) begin
                state <= SCAN;
                data1 <= active[0];
                data2 <= 3'd1;
              end else begin
                state   <= IDLE;
                data1   <= 3'd0;
                data2   <= 3'd0;
                disp_en <= 1'b0;
              end
            end else begin
              idx   <= idx_nxt;
              data1 <= idx_nxt;
            end
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          idx     <= 3'd0;
          data1   <= 3'd0;
          data2   <= 3'd0;
          disp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short dwell so whole frames and
// lamp tests run in a few hundred cycles.
module tb_seg7_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       lamp_req;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       commit;
  logic [2:0] data1;
  logic [2:0] data2;
  logic       disp_en;
  logic       frame_tick;
  logic       commit_pend;
  logic       lamp_done;

  int n_chk = 0;
  int n_err = 0;

  seg7_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .lamp_req(lamp_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .data1(data1), .data2(data2), .disp_en(disp_en), .frame_tick(frame_tick),
    .commit_pend(commit_pend), .lamp_done(lamp_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d1"}, int'(data1), 0);
    chk({tag, "_d2"}, int'(data2), 0);
    chk({tag, "_en"}, int'(disp_en), 0);
    chk({tag, "_ft"}, int'(frame_tick), 0);
    chk({tag, "_cp"}, int'(commit_pend), 0);
    chk({tag, "_ld"}, int'(lamp_done), 0);
  endtask

  // Checks one 24-cycle scan frame starting at digit 1, count 0.
  task automatic check_frame(input int v[6], input int tick0);
    for (int d = 0; d < 6; d++) begin
      for (int c = 0; c < DWELL; c++) begin
        chk($sformatf("frm_d2_%0d_%0d", d, c), int'(data2), d + 1);
        chk($sformatf("frm_d1_%0d_%0d", d, c), int'(data1), v[d]);
        chk($sformatf("frm_ft_%0d_%0d", d, c), int'(frame_tick),
            (d == 0 && c == 0) ? tick0 : 0);
        chk($sformatf("frm_en_%0d_%0d", d, c), int'(disp_en), 1);
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lamp_req = 1'b0; wr_en = 1'b0;
    wr_addr = 3'd0; wr_data = 3'd0; commit = 1'b0;
    #3;
    chk_all_zero("por");
    #10 rst = 1'b0;
    tick();
    chk("idle_en", int'(disp_en), 0);

    // Load shadow with 5..0 and commit while idle.
    for (int a = 0; a < 6; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 3'(5 - a);
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("idle_commit_pend", int'(commit_pend), 0);
    chk("idle_still_off", int'(disp_en), 0);

    en = 1'b1;
    tick();
    check_frame('{5, 4, 3, 2, 1, 0}, 0);

    // Mid-frame commit waits for the wrap.
    chk("f2_tick", int'(frame_tick), 1);
    chk("f2_d2", int'(data2), 1);
    tick(2);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 3'd7; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    chk("mid_pend", int'(commit_pend), 1);
    tick(5);
    chk("mid_dig3_d2", int'(data2), 3);
    chk("mid_dig3_old", int'(data1), 3);
    chk("mid_pend_hold", int'(commit_pend), 1);
    tick(16);
    chk("wrap_tick", int'(frame_tick), 1);
    chk("wrap_pend_clr", int'(commit_pend), 0);
    chk("wrap_d2", int'(data2), 1);
    tick(8);
    chk("new_dig3_d2", int'(data2), 3);
    chk("new_dig3_d1", int'(data1), 7);

    // Commit asserted in the last cycle before the wrap still applies there.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'd6;
    tick();
    wr_en = 1'b0;
    tick(14);
    chk("bnd_pre_pend", int'(commit_pend), 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("bnd_tick", int'(frame_tick), 1);
    chk("bnd_d2", int'(data2), 1);
    chk("bnd_d1", int'(data1), 6);
    chk("bnd_pend", int'(commit_pend), 0);

    // Out-of-range address is ignored.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 3'd7; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    tick(23);
    check_frame('{6, 4, 7, 2, 1, 0}, 1);

    // Lamp request during digit 3, serviced at the wrap.
    tick(8);
    lamp_req = 1'b1;
    tick();
    lamp_req = 1'b0;
    tick(15);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < DWELL; c++) begin
        chk($sformatf("lamp_d2_%0d_%0d", p, c), int'(data2), 0);
        chk($sformatf("lamp_d1_%0d_%0d", p, c), int'(data1), p);
        chk($sformatf("lamp_en_%0d_%0d", p, c), int'(disp_en), 1);
        chk($sformatf("lamp_ft_%0d_%0d", p, c), int'(frame_tick),
            (p == 0 && c == 0) ? 1 : 0);
        chk($sformatf("lamp_ld_%0d_%0d", p, c), int'(lamp_done), 0);
        if (p == 3 && c == 0) lamp_req = 1'b1;
        tick();
        lamp_req = 1'b0;
      end
    end
    chk("lamp_done", int'(lamp_done), 1);
    chk("lamp_done_ft", int'(frame_tick), 0);
    chk("resume_d2", int'(data2), 1);
    chk("resume_d1", int'(data1), 6);
    tick();
    chk("lamp_done_pulse", int'(lamp_done), 0);
    tick(23);
    chk("no_relamp_d2", int'(data2), 1);
    chk("no_relamp_ft", int'(frame_tick), 1);

    // Drop en in the second cycle of digit 4.
    tick(13);
    en = 1'b0;
    chk("dig4_c1", int'(data2), 4);
    tick();
    chk("dig4_c2", int'(data2), 4);
    tick();
    chk("dig4_c3", int'(data2), 4);
    chk("dig4_c3_d1", int'(data1), 2);
    tick();
    chk("off_en", int'(disp_en), 0);
    chk("off_d1", int'(data1), 0);
    chk("off_d2", int'(data2), 0);
    tick(2);
    chk("off_hold", int'(disp_en), 0);
    en = 1'b1;
    tick();
    chk("restart_d2", int'(data2), 1);
    chk("restart_d1", int'(data1), 6);
    chk("restart_ft", int'(frame_tick), 0);

    // Asynchronous reset mid-scan with a commit pending.
    tick(5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pre_rst_pend", int'(commit_pend), 1);
    chk("pre_rst_en", int'(disp_en), 1);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #1 rst = 1'b0;
    en = 1'b0;
    tick();
    chk("post_rst_idle", int'(disp_en), 0);
    chk("post_rst_d2", int'(data2), 0);
    en = 1'b1;
    tick();
    check_frame('{0, 0, 0, 0, 0, 0}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
